// File: rtl/hp_bytequad_pkg.sv
// Shared Tube host-to-parasite definitions: channel indices, default R3 depth, select decode.
// Optional build macro: HP_OVERFLOW_FLAG_EN (sticky write-when-full flags).
package hp_bytequad_pkg;

  localparam int R1_IDX = 0;
  localparam int R2_IDX = 1;
  localparam int R3_IDX = 2;
  localparam int R4_IDX = 3;

  localparam int R3_DEPTH_DEF = 2;
  localparam int BYTE_W       = 8;

  // Parasite side picks exactly one channel: the lowest set select bit.
  function automatic logic [3:0] lowest_sel(input logic [3:0] sel);
    logic [3:0] res;
    res = 4'b0000;
    if (sel[0])      res = 4'b0001;
    else if (sel[1]) res = 4'b0010;
    else if (sel[2]) res = 4'b0100;
    else if (sel[3]) res = 4'b1000;
    return res;
  endfunction

endpackage

// File: rtl/hp_bytequad_byte.sv
// Single-byte host-to-parasite latch with valid flag (used for R1, R2, R4).
// HP_OVERFLOW_FLAG_EN adds a sticky write-when-full flag.
module hp_byte
  import hp_bytequad_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              valid,
  output logic              overflow
);

  logic              pop;
  logic              push;
  logic [BYTE_W-1:0] data_q;
  logic              valid_q;

  // A same-cycle read frees the latch, so a write while full is accepted then.
  assign pop  = rd_req & valid_q;
  assign push = wr_req & (~valid_q | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push)
        data_q <= din;
      if (push)
        valid_q <= 1'b1;
      else if (pop)
        valid_q <= 1'b0;
    end
  end

  assign dout  = data_q;
  assign valid = valid_q;

`ifdef HP_OVERFLOW_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (wr_req & valid_q)
      ovf_q <= 1'b1;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: rtl/hp_bytequad.sv
// Host-to-parasite half of the Tube register file: R1/R2/R4 byte latches, R3 FIFO, PIRQ/PNMI.
// HP_OVERFLOW_FLAG_EN enables sticky per-channel write-when-full flags on h_overflow.
module hp_bytequad
  import hp_bytequad_pkg::*;
#(
  parameter int R3_DEPTH = R3_DEPTH_DEF,
  parameter int R3_CW    = 2
) (
  input  logic              h_phi2,
  input  logic              h_rst,
  input  logic              h_wr,
  input  logic [3:0]        h_selectData,
  input  logic [BYTE_W-1:0] h_data,
  input  logic              p_rd,
  input  logic [3:0]        p_selectData,
  input  logic              one_byte_mode,
  input  logic              irq_en_r1,
  input  logic              irq_en_r4,
  input  logic              nmi_en_r3,
  output logic [BYTE_W-1:0] p_data,
  output logic [3:0]        p_data_available,
  output logic [3:0]        h_full,
  output logic              hp_zero_r3_bytes_avail,
  output logic              p_irq,
  output logic              p_nmi,
  output logic [3:0]        h_overflow
);

  localparam int PW = (R3_DEPTH > 1) ? $clog2(R3_DEPTH) : 1;
  localparam logic [R3_CW-1:0] R3_FULL_CNT = R3_CW'(R3_DEPTH);
  localparam logic [PW-1:0]    PTR_LAST    = PW'(R3_DEPTH - 1);

  logic [3:0]        wr_req;
  logic [3:0]        rd_sel;
  logic [3:0]        rd_req;
  logic [BYTE_W-1:0] r1_data, r2_data, r4_data;
  logic              r1_vld, r2_vld, r4_vld;
  logic              r1_ovf, r2_ovf, r4_ovf;

  assign wr_req = {4{h_wr}} & h_selectData;
  assign rd_sel = lowest_sel(p_selectData);
  assign rd_req = {4{p_rd}} & rd_sel;

  hp_byte u_r1 (
    .clk      (h_phi2),
    .rst      (h_rst),
    .wr_req   (wr_req[R1_IDX]),
    .rd_req   (rd_req[R1_IDX]),
    .din      (h_data),
    .dout     (r1_data),
    .valid    (r1_vld),
    .overflow (r1_ovf)
  );

  hp_byte u_r2 (
    .clk      (h_phi2),
    .rst      (h_rst),
    .wr_req   (wr_req[R2_IDX]),
    .rd_req   (rd_req[R2_IDX]),
    .din      (h_data),
    .dout     (r2_data),
    .valid    (r2_vld),
    .overflow (r2_ovf)
  );

  hp_byte u_r4 (
    .clk      (h_phi2),
    .rst      (h_rst),
    .wr_req   (wr_req[R4_IDX]),
    .rd_req   (rd_req[R4_IDX]),
    .din      (h_data),
    .dout     (r4_data),
    .valid    (r4_vld),
    .overflow (r4_ovf)
  );

  logic [BYTE_W-1:0] r3_mem [R3_DEPTH];
  logic [PW-1:0]     r3_wp, r3_rp;
  logic [R3_CW-1:0]  r3_cnt;
  logic [R3_CW-1:0]  r3_cap;
  logic              r3_full;
  logic              r3_push, r3_pop;

  // Capacity follows one_byte_mode live; excess bytes simply drain.
  assign r3_cap  = one_byte_mode ? R3_CW'(1) : R3_FULL_CNT;
  assign r3_full = (r3_cnt >= r3_cap);
  assign r3_pop  = rd_req[R3_IDX] & (r3_cnt != '0);
  assign r3_push = wr_req[R3_IDX] & (~r3_full | r3_pop);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      r3_wp  <= '0;
      r3_rp  <= '0;
      r3_cnt <= '0;
      for (int i = 0; i < R3_DEPTH; i++)
        r3_mem[i] <= '0;
    end else begin
      if (r3_push) begin
        r3_mem[r3_wp] <= h_data;
        r3_wp         <= ptr_inc(r3_wp);
      end
      if (r3_pop)
        r3_rp <= ptr_inc(r3_rp);
      if (r3_push & ~r3_pop)
        r3_cnt <= r3_cnt + R3_CW'(1);
      else if (r3_pop & ~r3_push)
        r3_cnt <= r3_cnt - R3_CW'(1);
    end
  end

  always_comb begin
    p_data = '0;
    if (rd_sel[R1_IDX])      p_data = r1_data;
    else if (rd_sel[R2_IDX]) p_data = r2_data;
    else if (rd_sel[R3_IDX]) p_data = r3_mem[r3_rp];
    else if (rd_sel[R4_IDX]) p_data = r4_data;
  end

  assign p_data_available       = {r4_vld, (r3_cnt != '0), r2_vld, r1_vld};
  assign h_full                 = {r4_vld, r3_full, r2_vld, r1_vld};
  assign hp_zero_r3_bytes_avail = (r3_cnt == '0);

  // Requests are registered from current occupancy, so they trail it by one cycle.
  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst) begin
      p_irq <= 1'b0;
      p_nmi <= 1'b0;
    end else begin
      p_irq <= (irq_en_r1 & r1_vld) | (irq_en_r4 & r4_vld);
      p_nmi <= nmi_en_r3 & (one_byte_mode ? (r3_cnt != '0) : (r3_cnt == R3_FULL_CNT));
    end
  end

`ifdef HP_OVERFLOW_FLAG_EN
  logic r3_ovf;

  always_ff @(posedge h_phi2 or posedge h_rst) begin
    if (h_rst)
      r3_ovf <= 1'b0;
    else if (wr_req[R3_IDX] & r3_full)
      r3_ovf <= 1'b1;
  end

  assign h_overflow = {r4_ovf, r3_ovf, r2_ovf, r1_ovf};
`else
  logic unused_ovf;
  assign unused_ovf = r1_ovf ^ r2_ovf ^ r4_ovf;
  assign h_overflow = 4'b0000;
`endif

endmodule

// File: tb/tb_hp_bytequad.sv
// Directed bench for hp_bytequad: vector table plus hand-written multi-cycle sequences.
module tb_hp_bytequad;

  logic       h_phi2 = 1'b0;
  logic       h_rst;
  logic       h_wr;
  logic [3:0] h_selectData;
  logic [7:0] h_data;
  logic       p_rd;
  logic [3:0] p_selectData;
  logic       one_byte_mode;
  logic       irq_en_r1, irq_en_r4, nmi_en_r3;
  logic [7:0] p_data;
  logic [3:0] p_data_available;
  logic [3:0] h_full;
  logic       hp_zero_r3_bytes_avail;
  logic       p_irq, p_nmi;
  logic [3:0] h_overflow;

  int checks = 0;
  int errors = 0;

  always #5 h_phi2 = ~h_phi2;

  hp_bytequad #(.R3_DEPTH(2), .R3_CW(2)) dut (
    .h_phi2                 (h_phi2),
    .h_rst                  (h_rst),
    .h_wr                   (h_wr),
    .h_selectData           (h_selectData),
    .h_data                 (h_data),
    .p_rd                   (p_rd),
    .p_selectData           (p_selectData),
    .one_byte_mode          (one_byte_mode),
    .irq_en_r1              (irq_en_r1),
    .irq_en_r4              (irq_en_r4),
    .nmi_en_r3              (nmi_en_r3),
    .p_data                 (p_data),
    .p_data_available       (p_data_available),
    .h_full                 (h_full),
    .hp_zero_r3_bytes_avail (hp_zero_r3_bytes_avail),
    .p_irq                  (p_irq),
    .p_nmi                  (p_nmi),
    .h_overflow             (h_overflow)
  );

  typedef struct {
    logic       wr;
    logic [3:0] hsel;
    logic [7:0] hd;
    logic       rd;
    logic [3:0] psel;
    logic       chk_pd;
    logic [7:0] pd;
    logic [3:0] avail;
    logic [3:0] full;
    logic       zero;
  } vec_t;

  vec_t vt [13];

`ifdef HP_OVERFLOW_FLAG_EN
  localparam logic [3:0] OVF_R2 = 4'b0010;
`else
  localparam logic [3:0] OVF_R2 = 4'b0000;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge h_phi2);
    #2;
  endtask

  task automatic idle();
    h_wr = 1'b0; h_selectData = 4'b0; h_data = 8'h00;
    p_rd = 1'b0; p_selectData = 4'b0;
  endtask

  task automatic do_reset();
    idle();
    h_rst = 1'b1;
    tick();
    h_rst = 1'b0;
    chk("rst_avail", {28'b0, p_data_available}, 32'h0);
    chk("rst_full",  {28'b0, h_full}, 32'h0);
    chk("rst_zero",  {31'b0, hp_zero_r3_bytes_avail}, 32'h1);
    chk("rst_irq_nmi", {30'b0, p_irq, p_nmi}, 32'h0);
    chk("rst_ovf",   {28'b0, h_overflow}, 32'h0);
  endtask

  task automatic hwrite(input logic [3:0] sel, input logic [7:0] d);
    h_wr = 1'b1; h_selectData = sel; h_data = d;
    tick();
    idle();
  endtask

  initial begin
    vt[0]  = '{1, 4'b0001, 8'hA5, 0, 4'b0000, 1, 8'h00, 4'b0001, 4'b0001, 1};
    vt[1]  = '{0, 4'b0000, 8'h00, 1, 4'b0001, 1, 8'hA5, 4'b0000, 4'b0000, 1};
    vt[2]  = '{1, 4'b0100, 8'h11, 0, 4'b0000, 1, 8'h00, 4'b0100, 4'b0000, 0};
    vt[3]  = '{1, 4'b0100, 8'h22, 0, 4'b0000, 0, 8'h00, 4'b0100, 4'b0100, 0};
    vt[4]  = '{1, 4'b0100, 8'h33, 0, 4'b0000, 0, 8'h00, 4'b0100, 4'b0100, 0};
    vt[5]  = '{0, 4'b0000, 8'h00, 1, 4'b0100, 1, 8'h11, 4'b0100, 4'b0000, 0};
    vt[6]  = '{0, 4'b0000, 8'h00, 1, 4'b0100, 1, 8'h22, 4'b0000, 4'b0000, 1};
    vt[7]  = '{1, 4'b1011, 8'h5C, 0, 4'b0000, 0, 8'h00, 4'b1011, 4'b1011, 1};
    vt[8]  = '{0, 4'b0000, 8'h00, 1, 4'b1110, 1, 8'h5C, 4'b1001, 4'b1001, 1};
    vt[9]  = '{0, 4'b0000, 8'h00, 1, 4'b1000, 1, 8'h5C, 4'b0001, 4'b0001, 1};
    vt[10] = '{0, 4'b0000, 8'h00, 1, 4'b0000, 1, 8'h00, 4'b0001, 4'b0001, 1};
    vt[11] = '{0, 4'b0000, 8'h00, 1, 4'b0011, 1, 8'h5C, 4'b0000, 4'b0000, 1};
    vt[12] = '{0, 4'b0000, 8'h00, 1, 4'b0010, 0, 8'h00, 4'b0000, 4'b0000, 1};

    one_byte_mode = 1'b0; irq_en_r1 = 1'b0; irq_en_r4 = 1'b0; nmi_en_r3 = 1'b0;
    h_rst = 1'b0;
    idle();
    #1;
    do_reset();

    for (int i = 0; i < 13; i++) begin
      h_wr = vt[i].wr; h_selectData = vt[i].hsel; h_data = vt[i].hd;
      p_rd = vt[i].rd; p_selectData = vt[i].psel;
      #1;
      if (vt[i].chk_pd) chk($sformatf("vec%0d_pdata", i), {24'b0, p_data}, {24'b0, vt[i].pd});
      tick();
      idle();
      chk($sformatf("vec%0d_avail", i), {28'b0, p_data_available}, {28'b0, vt[i].avail});
      chk($sformatf("vec%0d_full", i),  {28'b0, h_full}, {28'b0, vt[i].full});
      chk($sformatf("vec%0d_zero", i),  {31'b0, hp_zero_r3_bytes_avail}, {31'b0, vt[i].zero});
    end

    // R1 interrupt path
    do_reset();
    irq_en_r1 = 1'b1;
    hwrite(4'b0001, 8'hA5);
    chk("irq_avail", {28'b0, p_data_available}, 32'h1);
    tick();
    chk("irq_set", {31'b0, p_irq}, 32'h1);
    p_rd = 1'b1; p_selectData = 4'b0001;
    #1;
    chk("irq_pdata", {24'b0, p_data}, 32'hA5);
    tick();
    idle();
    chk("irq_avail0", {28'b0, p_data_available}, 32'h0);
    tick();
    chk("irq_clr", {31'b0, p_irq}, 32'h0);
    irq_en_r1 = 1'b0;

    // R3 NMI in two-byte mode
    do_reset();
    nmi_en_r3 = 1'b1;
    hwrite(4'b0100, 8'h11);
    tick();
    chk("nmi_one", {31'b0, p_nmi}, 32'h0);
    hwrite(4'b0100, 8'h22);
    tick();
    chk("nmi_two", {31'b0, p_nmi}, 32'h1);
    chk("nmi_full", {31'b0, h_full[2]}, 32'h1);

    // one-byte mode, then switch back
    do_reset();
    one_byte_mode = 1'b1;
    hwrite(4'b0100, 8'h7E);
    chk("obm_full", {31'b0, h_full[2]}, 32'h1);
    tick();
    chk("obm_nmi", {31'b0, p_nmi}, 32'h1);
    one_byte_mode = 1'b0;
    #1;
    chk("obm_off_full", {31'b0, h_full[2]}, 32'h0);
    tick();
    chk("obm_off_nmi", {31'b0, p_nmi}, 32'h0);
    nmi_en_r3 = 1'b0;

    // R4 simultaneous read and write while full
    do_reset();
    hwrite(4'b1000, 8'h01);
    p_rd = 1'b1; p_selectData = 4'b1000;
    h_wr = 1'b1; h_selectData = 4'b1000; h_data = 8'h02;
    #1;
    chk("r4_old", {24'b0, p_data}, 32'h01);
    tick();
    idle();
    p_selectData = 4'b1000;
    #1;
    chk("r4_new", {24'b0, p_data}, 32'h02);
    chk("r4_vld", {31'b0, p_data_available[3]}, 32'h1);

    // Asynchronous reset mid-cycle
    do_reset();
    irq_en_r1 = 1'b1; nmi_en_r3 = 1'b1; one_byte_mode = 1'b1;
    hwrite(4'b0101, 8'h3C);
    tick();
    chk("arst_pre_irq", {30'b0, p_irq, p_nmi}, 32'h3);
    #1;
    h_rst = 1'b1;
    #1;
    chk("arst_avail", {28'b0, p_data_available}, 32'h0);
    chk("arst_full",  {28'b0, h_full}, 32'h0);
    chk("arst_zero",  {31'b0, hp_zero_r3_bytes_avail}, 32'h1);
    chk("arst_irq_nmi", {30'b0, p_irq, p_nmi}, 32'h0);
    tick();
    h_rst = 1'b0;
    irq_en_r1 = 1'b0; nmi_en_r3 = 1'b0; one_byte_mode = 1'b0;

    // R2 overflow flag
    do_reset();
    hwrite(4'b0010, 8'hAA);
    hwrite(4'b0010, 8'hBB);
    tick();
    chk("ovf_set", {28'b0, h_overflow}, {28'b0, OVF_R2});
    p_rd = 1'b1; p_selectData = 4'b0010;
    #1;
    chk("ovf_kept_data", {24'b0, p_data}, 32'hAA);
    tick();
    idle();
    tick();
    chk("ovf_sticky", {28'b0, h_overflow}, {28'b0, OVF_R2});
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
